// File: rtl/simple_gemac_flow_ctrl_tx.sv
// PAUSE-frame scheduler: XOFF on low RX FIFO space, periodic refresh, optional XON (SIMPLE_GEMAC_FC_XON_EN).
// Latency: condition at edge N -> pause_req in cycle N+1 when the gap counter is idle.
// Backpressure: none; events inside the MIN_GAP window wait in a one-deep pending slot, newest wins.
module simple_gemac_flow_ctrl_tx #(
  parameter int MIN_GAP    = 128,
  parameter int QUANTA_CYC = 64
) (
  input  logic        clk125,
  input  logic        reset_n,
  input  logic        pause_en,
  input  logic [15:0] rx_fifo_space,
  input  logic [15:0] pause_thresh,
  input  logic [15:0] resume_thresh,
  input  logic [15:0] pause_quanta,
  input  logic [15:0] refresh_quanta,
  output logic        pause_req,
  output logic [15:0] pause_time,
  output logic        xoff_active,
  output logic [15:0] pause_count
);

  localparam logic [15:0] GAP_LOAD   = 16'(MIN_GAP - 1);
  localparam logic [15:0] PRESC_LAST = 16'(QUANTA_CYC - 1);

`ifdef SIMPLE_GEMAC_FC_XON_EN
  localparam bit XON_EN = 1'b1;
`else
  localparam bit XON_EN = 1'b0;
`endif

  typedef enum logic {
    FC_IDLE   = 1'b0,
    FC_PAUSED = 1'b1
  } fc_state_t;

  fc_state_t   state, state_nxt;
  logic [15:0] pause_thresh_q, resume_thresh_q;
  logic [15:0] gap_cnt, presc, refresh_tmr;
  logic        pend_vld, pend_xon, pend_vld_nxt, pend_xon_nxt;
  logic        low_space, recovered, refresh_expired, presc_wrap;
  logic        ev_vld, ev_xon, tmr_load, cand_vld, cand_xon, fire;

  assign low_space       = rx_fifo_space < pause_thresh_q;
  assign recovered       = rx_fifo_space >= resume_thresh_q;
  assign refresh_expired = (refresh_tmr == 16'd0) && (refresh_quanta != 16'd0);
  assign presc_wrap      = presc == PRESC_LAST;
  assign xoff_active     = state == FC_PAUSED;

  always_comb begin
    state_nxt = state;
    ev_vld    = 1'b0;
    ev_xon    = 1'b0;
    tmr_load  = 1'b0;
    case (state)
      FC_IDLE: begin
        if (pause_en && low_space) begin
          ev_vld    = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = FC_PAUSED;
        end
      end
      FC_PAUSED: begin
        if (!pause_en || recovered) begin
          ev_vld    = 1'b1;
          ev_xon    = 1'b1;
          state_nxt = FC_IDLE;
        end else if (refresh_expired) begin
          ev_vld   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      default: state_nxt = FC_IDLE;
    endcase

    // A fresh event overrides the pending one; a suppressed XON still cancels a stale XOFF.
    cand_xon     = ev_vld ? ev_xon : pend_xon;
    cand_vld     = (ev_vld || pend_vld) && (XON_EN || !cand_xon);
    fire         = cand_vld && (gap_cnt == 16'd0);
    pend_vld_nxt = cand_vld && !fire;
    pend_xon_nxt = cand_xon && pend_vld_nxt;
  end

  always_ff @(posedge clk125 or negedge reset_n) begin
    if (!reset_n) begin
      state           <= FC_IDLE;
      pause_thresh_q  <= 16'd0;
      resume_thresh_q <= 16'd0;
      gap_cnt         <= 16'd0;
      presc           <= 16'd0;
      refresh_tmr     <= 16'd0;
      pend_vld        <= 1'b0;
      pend_xon        <= 1'b0;
      pause_req       <= 1'b0;
      pause_time      <= 16'd0;
      pause_count     <= 16'd0;
    end else begin
      state           <= state_nxt;
      pause_thresh_q  <= pause_thresh;
      resume_thresh_q <= resume_thresh;
      pend_vld        <= pend_vld_nxt;
      pend_xon        <= pend_xon_nxt;
      pause_req       <= fire;
      presc           <= presc_wrap ? 16'd0 : presc + 16'd1;

      if (fire) begin
        pause_time  <= cand_xon ? 16'd0 : pause_quanta;
        pause_count <= pause_count + 16'd1;
        gap_cnt     <= GAP_LOAD;
      end else if (gap_cnt != 16'd0) begin
        gap_cnt <= gap_cnt - 16'd1;
      end

      if (tmr_load)
        refresh_tmr <= refresh_quanta;
      else if (presc_wrap && refresh_tmr != 16'd0)
        refresh_tmr <= refresh_tmr - 16'd1;
    end
  end

endmodule
